ramio_bram: RTL and testbench

Byte-addressed, word-organised on-chip RAM with the RAMIO request interface that the core drives. It accepts byte, half-word and word writes, and zero- or sign-extended reads, through an enable/busy handshake. It returns read data with a one-cycle `data_out_ready` pulse. It sits directly downstream of the core's flash-copy and test logic and is the store that flash contents are copied into.

---
 rtl/ramio_bram_if.sv | 23 ++
 rtl/ramio_bram.sv | 159 +++++++++++++++
 tb/tb_ramio_bram.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramio_bram_if.sv
// RAMIO request/response bundle: the requester drives enable, the access
// types, the byte address and write data; the RAM returns extended read data,
// a one-cycle ready strobe and busy.
interface ramio_bram_if;
    logic        enable;
    logic [1:0]  write_type;
    logic [2:0]  read_type;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;

    modport master (
        output enable, write_type, read_type, address, data_in,
        input  data_out, data_out_ready, busy
    );

    modport slave (
        input  enable, write_type, read_type, address, data_in,
        output data_out, data_out_ready, busy
    );
endinterface

// File: rtl/ramio_bram.sv
// Byte-addressed, word-organised on-chip RAM behind the RAMIO enable/busy
// handshake. Writes use per-lane byte enables, so no read-modify-write is
// needed. Reads take two cycles: register the word, then select/extend a lane.
module ramio_bram #(
    parameter int DEPTH_BITWIDTH = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    ramio_bram_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_BITWIDTH;
    localparam int AW    = DEPTH_BITWIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ_MEM,
        S_READ_OUT
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic        accept;
    logic [AW-1:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  wtype_q;
    logic [2:0]  rtype_q;
    logic [31:0] data_out_q, data_out_d;
    logic        ready_q, ready_d;

    logic [DEPTH_BITWIDTH-1:0] word_idx;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic [31:0] rd_word;
    logic [31:0] read_ext;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Address bits above the memory depth alias away by design.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.address[31:AW]};

    assign word_idx           = addr_q[AW-1:2];
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.data_out       = data_out_q;
    assign bus.data_out_ready = ready_q;

    // Next-state logic: one acceptance per armed enable, write beats read.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        accept     = bus.enable && armed_q && (state_q == S_IDLE);

        if (!bus.enable) begin
            armed_d = 1'b1;
        end else if (accept) begin
            armed_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.write_type != 2'b00) begin
                        state_d = S_WRITE;
                    end else if (bus.read_type[1:0] != 2'b00) begin
                        state_d = S_READ_MEM;
                    end
                end
            end
            S_WRITE:    state_d = S_IDLE;
            S_READ_MEM: state_d = S_READ_OUT;
            S_READ_OUT: begin
                state_d    = S_IDLE;
                ready_d    = 1'b1;
                data_out_d = read_ext;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // State, handshake and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            wtype_q    <= '0;
            rtype_q    <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            if (accept) begin
                addr_q  <= bus.address[AW-1:0];
                wdata_q <= bus.data_in;
                wtype_q <= bus.write_type;
                rtype_q <= bus.read_type;
            end
        end
    end

    // Byte enables and lane-replicated write data, active only in WRITE.
    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = wdata_q;
        case (wtype_q)
            2'b01: begin
                lane_we    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b10: begin
                lane_we    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            2'b11: lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
        if (state_q != S_WRITE) begin
            lane_we = 4'b0000;
        end
    end

    // Lane selection and zero/sign extension of the registered word.
    always_comb begin
        sel_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
        sel_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (rtype_q[1:0])
            2'b01:   read_ext = rtype_q[2] ? {{24{sel_byte[7]}}, sel_byte}
                                           : {24'h0, sel_byte};
            2'b10:   read_ext = rtype_q[2] ? {{16{sel_half[15]}}, sel_half}
                                           : {16'h0, sel_half};
            default: read_ext = rd_word;
        endcase
    end

    // One block RAM per byte lane so each lane has its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Byte-lane write and registered read (no reset: contents persist).
        always_ff @(posedge clk) begin
            if (lane_we[gi]) begin
                mem[word_idx] <= lane_wdata[gi*8 +: 8];
            end
            if (state_q == S_READ_MEM) begin
                rd_q <= mem[word_idx];
            end
        end

        assign rd_word[gi*8 +: 8] = rd_q;
    end
endmodule

// File: tb/tb_ramio_bram.sv
// Self-checking bench for ramio_bram: directed test-plan steps followed by
// randomized accesses, all checked against a byte-array reference model.
module tb_ramio_bram;
    localparam int DW     = 4;
    localparam int NBYTES = 4 << DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ramio_bram_if bus();

    ramio_bram #(.DEPTH_BITWIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total  = 0;
    int passed = 0;
    logic [7:0] mem_m [NBYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int addr, input logic [1:0] wt, input logic [31:0] d);
        int a;
        a = addr % NBYTES;
        case (wt)
            2'd1: mem_m[a] = d[7:0];
            2'd2: begin
                a = a - (a % 2);
                mem_m[a]   = d[7:0];
                mem_m[a+1] = d[15:8];
            end
            2'd3: begin
                a = a - (a % 4);
                for (int k = 0; k < 4; k++) mem_m[a+k] = d[8*k +: 8];
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input int addr, input logic [2:0] rt);
        int a;
        logic [31:0] v;
        a = addr % NBYTES;
        v = 32'h0;
        case (rt[1:0])
            2'd1: begin
                v = {24'h0, mem_m[a]};
                if (rt[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
            end
            2'd2: begin
                a = a - (a % 2);
                v = mem_m[a] + (mem_m[a+1] * 256);
                if (rt[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
            end
            2'd3: begin
                a = a - (a % 4);
                for (int k = 0; k < 4; k++) v = v + (mem_m[a+k] << (8*k));
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic do_write(input int addr, input logic [1:0] wt, input logic [2:0] rt,
                            input logic [31:0] d);
        bus.enable     = 1'b1;
        bus.address    = addr;
        bus.write_type = wt;
        bus.read_type  = rt;
        bus.data_in    = d;
        tick();
        check($sformatf("wr_busy_e0@%0h", addr), bus.busy, 1'b1);
        bus.address = $urandom;
        bus.data_in = $urandom;
        tick();
        check($sformatf("wr_busy_e1@%0h", addr), bus.busy, 1'b0);
        check($sformatf("wr_rdy_e1@%0h", addr), bus.data_out_ready, 1'b0);
        model_write(addr, wt, d);
        bus.enable = 1'b0;
        tick();
        check($sformatf("wr_rdy_e2@%0h", addr), bus.data_out_ready, 1'b0);
        $display("write addr=%h type=%0d data=%h", addr, wt, d);
    endtask

    task automatic do_read(input int addr, input logic [2:0] rt);
        logic [31:0] exp;
        exp = model_read(addr, rt);
        bus.enable     = 1'b1;
        bus.address    = addr;
        bus.write_type = 2'b00;
        bus.read_type  = rt;
        tick();
        check("rd_busy_e0", bus.busy, 1'b1);
        check("rd_rdy_e0", bus.data_out_ready, 1'b0);
        bus.address   = $urandom;
        bus.read_type = 3'($urandom);
        tick();
        check("rd_busy_e1", bus.busy, 1'b1);
        check("rd_rdy_e1", bus.data_out_ready, 1'b0);
        tick();
        check("rd_busy_e2", bus.busy, 1'b0);
        check("rd_rdy_e2", bus.data_out_ready, 1'b1);
        check($sformatf("rd_data@%0h/t%0d", addr, rt), bus.data_out, exp);
        bus.enable = 1'b0;
        tick();
        check("rd_rdy_e3", bus.data_out_ready, 1'b0);
        check("rd_hold_e3", bus.data_out, exp);
        $display("read  addr=%h type=%03b data=%h expected=%h", addr, rt, bus.data_out, exp);
    endtask

    initial begin
        int pulses;
        int addr;
        logic [1:0] wt;
        logic [2:0] rt;

        bus.enable     = 1'b0;
        bus.write_type = 2'b00;
        bus.read_type  = 3'b000;
        bus.address    = 32'h0;
        bus.data_in    = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rdy", bus.data_out_ready, 1'b0);
        check("rst_data", bus.data_out, 32'h0);
        rst_n = 1'b1;
        tick();

        // Prefill every word so the model is fully defined
        for (int w = 0; w < NBYTES / 4; w++) do_write(w * 4, 2'b11, 3'b000, $urandom);

        // Word write then word read
        do_write(32'h0, 2'b11, 3'b000, 32'hDEADBEEF);
        do_read(32'h0, 3'b011);

        // Byte write into a word, then lane reads with extension
        do_write(32'h4, 2'b11, 3'b000, 32'h11223344);
        do_write(32'h5, 2'b01, 3'b000, 32'hABCDEF80);
        do_read(32'h4, 3'b011);
        check("plan_word_after_byte", bus.data_out, 32'h11228044);
        do_read(32'h5, 3'b101);
        check("plan_byte_sext", bus.data_out, 32'hFFFFFF80);
        do_read(32'h5, 3'b001);
        check("plan_byte_zext", bus.data_out, 32'h00000080);

        // Half-word reads
        do_write(32'h4, 2'b11, 3'b000, 32'h80015537);
        do_read(32'h4, 3'b010);
        check("plan_half_lo", bus.data_out, 32'h00005537);
        do_read(32'h6, 3'b110);
        check("plan_half_hi_sext", bus.data_out, 32'hFFFF8001);
        do_read(32'h7, 3'b110);
        check("plan_half_odd", bus.data_out, 32'hFFFF8001);

        // Half write into upper lane
        do_write(32'h0A, 2'b10, 3'b000, 32'h5555BEEF);
        do_read(32'h8, 3'b011);

        // Enable held high: exactly one operation, re-arm gives a second
        pulses = 0;
        bus.enable     = 1'b1;
        bus.address    = 32'h0;
        bus.write_type = 2'b00;
        bus.read_type  = 3'b011;
        repeat (6) begin
            tick();
            if (bus.data_out_ready) pulses++;
        end
        bus.enable = 1'b0;
        tick();
        if (bus.data_out_ready) pulses++;
        check("held_one_pulse", pulses, 1);
        bus.enable = 1'b1;
        repeat (5) begin
            tick();
            if (bus.data_out_ready) pulses++;
        end
        bus.enable = 1'b0;
        tick();
        if (bus.data_out_ready) pulses++;
        check("rearm_second_pulse", pulses, 2);
        check("held_data", bus.data_out, model_read(0, 3'b011));

        // No-op request: both types zero
        bus.enable     = 1'b1;
        bus.write_type = 2'b00;
        bus.read_type  = 3'b000;
        tick();
        check("noop_busy0", bus.busy, 1'b0);
        tick();
        check("noop_busy1", bus.busy, 1'b0);
        bus.enable = 1'b0;
        tick();

        // Reset in the middle of a read
        do_write(32'h8, 2'b11, 3'b000, 32'h12345678);
        do_read(32'h8, 3'b011);
        bus.enable    = 1'b1;
        bus.address   = 32'h8;
        bus.read_type = 3'b011;
        tick();
        check("mid_rd_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_rd_busy", bus.busy, 1'b0);
        check("rst_rd_data", bus.data_out, 32'h0);
        bus.enable = 1'b0;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            tick();
            if (bus.data_out_ready) pulses++;
        end
        check("rst_no_pulse", pulses, 0);
        do_read(32'h8, 3'b011);
        check("rst_preserved", bus.data_out, 32'h12345678);

        // Reset before a write commits drops the write
        bus.enable     = 1'b1;
        bus.address    = 32'hC;
        bus.write_type = 2'b11;
        bus.read_type  = 3'b000;
        bus.data_in    = 32'h0BAD0BAD;
        tick();
        rst_n = 1'b0;
        #1;
        bus.enable     = 1'b0;
        bus.write_type = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        do_read(32'hC, 3'b011);

        // Address aliasing beyond the depth
        do_write(32'h40, 2'b11, 3'b000, 32'hCAFEF00D);
        do_read(32'h0, 3'b011);
        check("plan_alias", bus.data_out, 32'hCAFEF00D);

        // Write and read requested together: write only, no ready
        do_write(32'h10, 2'b11, 3'b011, 32'hA5A55A5A);
        tick();
        check("wr_rd_no_pulse", bus.data_out_ready, 1'b0);
        do_read(32'h10, 3'b011);

        // Randomized accesses, including aliased addresses
        for (int i = 0; i < 80; i++) begin
            addr = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) begin
                wt = 2'($urandom_range(1, 3));
                do_write(addr, wt, 3'($urandom), $urandom);
            end else begin
                rt = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
                do_read(addr, rt);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
